// File: rtl/countdown_timer_if.sv
// Load/enable/setting inputs and registered MM:SS outputs of the countdown timer.
interface countdown_timer_if;
  logic       load_timer;
  logic       main_timer_enable;
  logic [3:0] set_min_tens;
  logic [3:0] set_min_ones;
  logic [3:0] set_sec_tens;
  logic [3:0] set_sec_ones;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       timer_done;
  logic       done_pulse;
  logic       sec_tick;

  modport master (
    output load_timer, main_timer_enable,
    output set_min_tens, set_min_ones, set_sec_tens, set_sec_ones,
    input  min_tens, min_ones, sec_tens, sec_ones,
    input  timer_done, done_pulse, sec_tick
  );

  modport slave (
    input  load_timer, main_timer_enable,
    input  set_min_tens, set_min_ones, set_sec_tens, set_sec_ones,
    output min_tens, min_ones, sec_tens, sec_ones,
    output timer_done, done_pulse, sec_tick
  );
endinterface

// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer with a TICK_DIV-cycle one-second prescaler,
// clamped loading, pause, and done/tick pulses.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input logic             clk,
  input logic             reset,
  countdown_timer_if.slave tif
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
  logic [3:0]    min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
  logic          done_q, done_d;
  logic          done_pulse_q, done_pulse_d;
  logic          sec_tick_q, sec_tick_d;
  logic          advance, tick;

  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  // done_q gates advancing, so a decrement is never attempted at 00:00.
  assign advance = tif.main_timer_enable && !tif.load_timer && !done_q;
  assign tick    = advance && (presc_q == PMAX);

  always_comb begin
    presc_d    = presc_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    if (tif.load_timer) begin
      presc_d    = '0;
      min_tens_d = clamp(tif.set_min_tens, 4'd9);
      min_ones_d = clamp(tif.set_min_ones, 4'd9);
      sec_tens_d = clamp(tif.set_sec_tens, 4'd5);
      sec_ones_d = clamp(tif.set_sec_ones, 4'd9);
    end else if (tick) begin
      presc_d = '0;
      if (sec_ones_q != 4'd0) begin
        sec_ones_d = sec_ones_q - 4'd1;
      end else begin
        sec_ones_d = 4'd9;
        if (sec_tens_q != 4'd0) begin
          sec_tens_d = sec_tens_q - 4'd1;
        end else begin
          sec_tens_d = 4'd5;
          if (min_ones_q != 4'd0) begin
            min_ones_d = min_ones_q - 4'd1;
          end else begin
            min_ones_d = 4'd9;
            min_tens_d = min_tens_q - 4'd1;
          end
        end
      end
    end else if (advance) begin
      presc_d = presc_q + PW'(1);
    end
    done_d       = ({min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} == 16'h0000);
    done_pulse_d = tick && done_d;
    sec_tick_d   = tick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      min_tens_q   <= 4'd0;
      min_ones_q   <= 4'd0;
      sec_tens_q   <= 4'd0;
      sec_ones_q   <= 4'd0;
      done_q       <= 1'b1;
      done_pulse_q <= 1'b0;
      sec_tick_q   <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      min_tens_q   <= min_tens_d;
      min_ones_q   <= min_ones_d;
      sec_tens_q   <= sec_tens_d;
      sec_ones_q   <= sec_ones_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      sec_tick_q   <= sec_tick_d;
    end
  end

  assign tif.min_tens   = min_tens_q;
  assign tif.min_ones   = min_ones_q;
  assign tif.sec_tens   = sec_tens_q;
  assign tif.sec_ones   = sec_ones_q;
  assign tif.timer_done = done_q;
  assign tif.done_pulse = done_pulse_q;
  assign tif.sec_tick   = sec_tick_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4: per-cycle vector table
// plus hand sequences for expiry, pause/resume and mid-count reset.
module tb_countdown_timer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total = 0;

  countdown_timer_if tif ();

  countdown_timer #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .tif   (tif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        load;
    logic        en;
    logic [15:0] set;
    logic [15:0] exp;
    logic        done;
    logic        pulse;
    logic        tick;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic load, input logic en, input logic [15:0] set,
                     input logic [15:0] exp, input logic done, input logic pulse,
                     input logic tick);
    vec_t v;
    v.rst = rst; v.load = load; v.en = en; v.set = set;
    v.exp = exp; v.done = done; v.pulse = pulse; v.tick = tick;
    vecs.push_back(v);
  endtask

  task automatic drive_cycle(input logic rst, input logic load, input logic en,
                             input logic [15:0] set);
    @(negedge clk);
    reset                 = rst;
    tif.load_timer        = load;
    tif.main_timer_enable = en;
    {tif.set_min_tens, tif.set_min_ones, tif.set_sec_tens, tif.set_sec_ones} = set;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] outs();
    return {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones,
            tif.timer_done, tif.done_pulse, tif.sec_tick};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  initial begin
    logic [18:0] o;
    int pulses, pulse_cyc, extra;
    logic done_at_pulse, bad;

    tif.load_timer = 1'b0;
    tif.main_timer_enable = 1'b0;
    {tif.set_min_tens, tif.set_min_ones, tif.set_sec_tens, tif.set_sec_ones} = 16'h0000;

    // Reset state, then 01:02 counting down through a minute borrow.
    add(1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    add(1, 1, 1, 16'h0102, 16'h0000, 1, 0, 0);
    add(0, 0, 1, 16'h0000, 16'h0000, 1, 0, 0);
    add(0, 1, 1, 16'h0102, 16'h0102, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      logic [15:0] e;
      e = (i < 4) ? 16'h0102 : (i < 8) ? 16'h0101 : (i < 12) ? 16'h0100 : 16'h0059;
      add(0, 0, 1, 16'h0000, e, 0, 0, (i % 4) == 0);
    end
    // Load wins over a terminal-count tick and clears the prescaler.
    add(0, 1, 1, 16'h0010, 16'h0010, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 16'h0000, 16'h0010, 0, 0, 0);
    add(0, 1, 1, 16'h0030, 16'h0030, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 16'h0000, 16'h0030, 0, 0, 0);
    add(0, 0, 1, 16'h0000, 16'h0029, 0, 0, 1);
    // Clamping of out-of-range set digits.
    add(0, 1, 0, 16'hCF7B, 16'h9959, 0, 0, 0);
    add(0, 1, 1, 16'h0A6A, 16'h0959, 0, 0, 0);
    // Loading 00:00: done without pulse, no decrement below zero.
    add(0, 1, 1, 16'h0000, 16'h0000, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 16'h0000, 16'h0000, 1, 0, 0);
    // Re-arm from done with 00:01, expire, done_pulse once.
    add(0, 1, 1, 16'h0001, 16'h0001, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 16'h0000, 16'h0001, 0, 0, 0);
    add(0, 0, 1, 16'h0000, 16'h0000, 1, 1, 1);
    add(0, 0, 1, 16'h0000, 16'h0000, 1, 0, 0);
    // Reset beats a simultaneous load.
    add(0, 1, 1, 16'h0003, 16'h0003, 0, 0, 0);
    add(1, 1, 1, 16'h0045, 16'h0000, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_cycle(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].set);
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vecs[i].exp, vecs[i].done, vecs[i].pulse, vecs[i].tick}));
    end

    // 00:02 expires after exactly 8 enabled cycles with a single done_pulse.
    drive_cycle(0, 1, 1, 16'h0002);
    check("load_0002", 32'(outs()), 32'({16'h0002, 3'b000}));
    pulses = 0; pulse_cyc = -1; done_at_pulse = 0; bad = 0;
    for (int i = 1; i <= 12; i++) begin
      drive_cycle(0, 0, 1, 16'h0000);
      o = outs();
      if (o[1]) begin
        pulses++; pulse_cyc = i; done_at_pulse = o[2];
      end
      if (i == 7 && o[18:3] != 16'h0001) bad = 1;
      if (i >= 8 && (o[18:3] != 16'h0000 || !o[2])) bad = 1;
    end
    check("expire_pulse_count", 32'(pulses), 32'd1);
    check("expire_pulse_cycle", 32'(pulse_cyc), 32'd8);
    check("expire_done_with_pulse", 32'(done_at_pulse), 32'd1);
    check("expire_hold_zero", 32'(bad), 32'd0);

    // Pause/resume keeps prescaler phase.
    drive_cycle(0, 1, 1, 16'h0005);
    for (int i = 1; i <= 6; i++) begin
      drive_cycle(0, 0, 1, 16'h0000);
      if (i == 3) check("pause_pre_tick", 32'(outs()), 32'({16'h0005, 3'b000}));
      if (i == 4) check("pause_first_tick", 32'(outs()), 32'({16'h0004, 3'b001}));
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(0, 0, 0, 16'h0000);
      if (outs() != {16'h0004, 3'b000}) bad = 1;
    end
    check("pause_hold", 32'(bad), 32'd0);
    drive_cycle(0, 0, 1, 16'h0000);
    check("resume_1", 32'(outs()), 32'({16'h0004, 3'b000}));
    drive_cycle(0, 0, 1, 16'h0000);
    check("resume_2", 32'(outs()), 32'({16'h0003, 3'b001}));

    // Reset mid-count at 00:03, then nothing moves with enable held.
    drive_cycle(0, 0, 1, 16'h0000);
    drive_cycle(1, 0, 1, 16'h0000);
    check("midreset", 32'(outs()), 32'({16'h0000, 3'b100}));
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(0, 0, 1, 16'h0000);
      if (outs() != {16'h0000, 3'b100}) extra++;
    end
    check("post_reset_hold", 32'(extra), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clk cycles per one-second decrement; legal range 2 to 2^27.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load_timer  input  1  one-cycle request to load the set digits into the countdown.
REQ-005 main_timer_enable  input  1  level; high = count down, low = pause.
REQ-006 set_min_tens, set_min_ones, set_sec_tens, set_sec_ones  input  4 each  BCD setting digits from the setting counters.
REQ-007 min_tens, min_ones, sec_tens, sec_ones  output  4 each  registered BCD remaining time, MM:SS, range 00:00 to 99:59.
REQ-008 timer_done  output  1  registered; high while remaining time is 00:00.
REQ-009 done_pulse  output  1  registered one-cycle pulse when a countdown decrement reaches 00:00.
REQ-010 sec_tick  output  1  registered one-cycle pulse on each applied one-second decrement, for the display colon.

Function
REQ-011 Internal prescaler counts 0 to TICK_DIV-1 (width ceil(log2(TICK_DIV))); it advances only when main_timer_enable=1, load_timer=0 and timer_done=0.
REQ-012 When the prescaler equals TICK_DIV-1 and is advancing, it wraps to 0 and the remaining time decrements by one second in that same edge.
REQ-013 When main_timer_enable=0, prescaler and digits hold (pause); resuming continues from the held prescaler value, no phase loss.
REQ-014 Decrement: sec_ones 0 borrows to 9; sec_tens 0 borrows to 5; min_ones 0 borrows to 9; min_tens decrements on min_ones borrow.
REQ-015 No decrement at 00:00; digits never wrap below 00:00.
REQ-016 load_timer=1 copies set digits into the outputs and clears the prescaler on the next edge; load has priority over an enabled tick in the same cycle.
REQ-017 Load clamping: any set digit above 9 loads as 9; set_sec_tens above 5 loads as 5.
REQ-018 timer_done equals (all four output digits == 0), updated on the same edge as the digits; zero-cycle lag relative to the digits.
REQ-019 Loading 00:00 sets timer_done=1 on the next edge; done_pulse stays 0.
REQ-020 done_pulse=1 for exactly one cycle, on the edge where a decrement moves 00:01 to 00:00; never from load or reset.
REQ-021 sec_tick=1 for exactly one cycle on every edge where REQ-012 decrements; 0 otherwise, including while paused or loading.
REQ-022 Load of a nonzero value while timer_done=1 clears timer_done on the next edge and re-arms counting.
REQ-023 Full count latency: a loaded value of N seconds reaches 00:00 after exactly N*TICK_DIV enabled cycles following the load edge.

Reset
REQ-024 reset=1 on a rising edge forces all digits to 0, prescaler to 0, timer_done=1, done_pulse=0, sec_tick=0.
REQ-025 reset has priority over load_timer and enable; reset mid-countdown abandons the count with no done_pulse.
REQ-026 After reset deasserts, no decrement occurs until a nonzero load.

Verification (TICK_DIV=4)
REQ-027 Load 01:02, enable held -> sec_tick every 4 cycles; digits 01:01, 01:00, 00:59; 00:59 appears 12 cycles after load edge.
REQ-028 Load 00:02, enable held -> 00:00 after 8 cycles; done_pulse high exactly one cycle, with timer_done rising on that same edge and staying high.
REQ-029 Load 00:05, enable 6 cycles, low 10 cycles, high again -> 00:04 after cycle 4, hold during pause, 00:03 exactly 2 enabled cycles after resume.
REQ-030 Load and prescaler terminal count in same cycle with 00:10 present, set 00:30 -> digits 00:30, prescaler 0, no sec_tick.
REQ-031 Load set digits 12/15/7/11 (min_tens=12, min_ones=15, sec_tens=7, sec_ones=11) -> outputs 9 9 5 9 (99:59).
REQ-032 Reset asserted at 00:03 mid-count -> next edge all digits 0, timer_done=1, done_pulse=0; holds 00:00 with enable high.
